perf_monitor: RTL and testbench

//  Synthesisable pipeline performance monitor that sits beside the CPU. Counts elapsed cycles and
//  NUM_EVT event channels (stall, flush, ...) while the core runs, and stops after a cycle limit.

---
 rtl/perf_mon_pkg.sv | 19 +
 rtl/perf_event_counter.sv | 52 +++++
 rtl/perf_monitor.sv | 118 +++++++++++
 tb/tb_perf_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/perf_mon_pkg.sv
// Shared definitions for the pipeline performance monitor: FSM encoding,
// event channel indices and readout select constants.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } perf_state_e;

  // Event channel indices into evt_i
  localparam int unsigned EVT_STALL = 0;
  localparam int unsigned EVT_FLUSH = 1;

  // Readout select for the elapsed-cycle counter; channel k is at select k+1
  localparam int unsigned SEL_CYCLE = 0;

endpackage

// File: rtl/perf_event_counter.sv
// One CNT_W-bit event counter with synchronous clear and a sticky overflow flag.
// Build option: PERF_SATURATE_EN makes the counter stick at all-ones instead of wrapping.
module perf_event_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // Next count: clear wins over increment; all-ones + 1 flags overflow
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
`ifdef PERF_SATURATE_EN
        cnt_d = cnt_q;
`else
        cnt_d = '0;
`endif
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and overflow state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: counts elapsed run cycles and NUM_EVT event channels,
// stops at MAX_CYCLES (0 = unlimited), and exposes counters through a request/ack port.
// Build option: PERF_SATURATE_EN (inside perf_event_counter) selects saturating counters.
module perf_monitor
  import perf_mon_pkg::*;
#(
  parameter  int unsigned NUM_EVT    = 2,
  parameter  int unsigned CNT_W      = 32,
  parameter  int unsigned MAX_CYCLES = 64,
  localparam int unsigned SEL_W      = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clr_i,
  input  logic               freeze_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               rd_req_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic               rd_ack_o,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               done_o,
  output logic [NUM_EVT:0]   ovf_o
);

  localparam logic [CNT_W-1:0] LastCycle = CNT_W'(MAX_CYCLES - 1);

  perf_state_e state_q, state_d;
  logic        count_en;
  logic        done_q;
  logic [NUM_EVT:0]            inc;
  logic [NUM_EVT:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]            rd_mux;
  logic                        rd_ack_q;
  logic [CNT_W-1:0]            rd_data_q;

  // Next state and count enable; clear beats freeze, freeze beats counting
  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    if (clr_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (start_i) state_d = StRun;
        StRun: begin
          if (freeze_i) begin
            state_d = StHold;
          end else if (start_i) begin
            count_en = 1'b1;
            // The cycle counter is about to reach the limit
            if ((MAX_CYCLES != 0) && (cnt[SEL_CYCLE] == LastCycle)) state_d = StDone;
          end
        end
        StHold: if (!freeze_i) state_d = StRun;
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM state and registered done flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == StDone);
    end
  end

  // Per-counter increment strobes: slot 0 is the cycle counter, slot k+1 is channel k
  always_comb begin
    inc            = '0;
    inc[SEL_CYCLE] = count_en;
    for (int k = 0; k < NUM_EVT; k++) begin
      inc[k+1] = count_en & evt_i[k];
    end
  end

  for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
    perf_event_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clr_i(clr_i),
      .inc_i(inc[g]),
      .cnt_o(cnt[g]),
      .ovf_o(ovf_o[g])
    );
  end

  // Readout select; out-of-range selects read as zero
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k <= NUM_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_mux = cnt[k];
    end
  end

  // Readout register: captures the pre-increment value, holds between requests
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q <= rd_req_i;
      if (rd_req_i) rd_data_q <= rd_mux;
    end
  end

  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed self-checking bench for perf_monitor. Instance u_dut uses the default
// configuration; u_dut8 (CNT_W=8, unlimited) shares the stimulus and is checked for wrap.
module tb_perf_monitor;
  import perf_mon_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic       freeze = 1'b0;
  logic [1:0] evt = 2'b00;
  logic       rd_req = 1'b0;
  logic [1:0] rd_sel = 2'd0;

  logic        ack_a, done_a;
  logic [31:0] data_a;
  logic [2:0]  ovf_a;
  logic        ack_b, done_b;
  logic [7:0]  data_b;
  logic [2:0]  ovf_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_monitor #(
    .NUM_EVT(2),
    .CNT_W(32),
    .MAX_CYCLES(64)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .clr_i(clr),
    .freeze_i(freeze),
    .evt_i(evt),
    .rd_req_i(rd_req),
    .rd_sel_i(rd_sel),
    .rd_ack_o(ack_a),
    .rd_data_o(data_a),
    .done_o(done_a),
    .ovf_o(ovf_a)
  );

  perf_monitor #(
    .NUM_EVT(2),
    .CNT_W(8),
    .MAX_CYCLES(0)
  ) u_dut8 (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .clr_i(clr),
    .freeze_i(freeze),
    .evt_i(evt),
    .rd_req_i(rd_req),
    .rd_sel_i(rd_sel),
    .rd_ack_o(ack_b),
    .rd_data_o(data_b),
    .done_o(done_b),
    .ovf_o(ovf_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle read of u_dut; consecutive calls produce back-to-back requests
  task automatic read_a(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
    check({tag, "_ack"}, 64'(ack_a), 64'd1);
    check(tag, 64'(data_a), 64'(exp));
  endtask

  initial begin
    // Reset
    ticks(2);
    rst = 1'b0;
    tick();
    check("rst_ack", 64'(ack_a), 64'd0);
    check("rst_data", 64'(data_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_ovf", 64'(ovf_a), 64'd0);

    // 1: ten counted cycles (first start edge only leaves IDLE)
    start = 1'b1;
    tick();
    ticks(10);
    start = 1'b0;
    read_a("t1_ch0", 2'(EVT_STALL + 1), 32'd0);
    read_a("t1_ch1", 2'(EVT_FLUSH + 1), 32'd0);
    read_a("t1_cyc", 2'(SEL_CYCLE), 32'd10);
    tick();
    check("t1_ack_drop", 64'(ack_a), 64'd0);
    check("t1_data_hold", 64'(data_a), 64'd10);

    // 2: events in RUN, then freeze with events still high
    start = 1'b1;
    evt = 2'b11;
    tick();
    evt = 2'b01;
    ticks(2);
    freeze = 1'b1;
    evt = 2'b11;
    ticks(5);
    freeze = 1'b0;
    start = 1'b0;
    evt = 2'b00;
    tick();
    read_a("t2_cyc", 2'd0, 32'd13);
    read_a("t2_ch0", 2'd1, 32'd3);
    read_a("t2_ch1", 2'd2, 32'd1);

    // 3: run to the 64-cycle limit
    start = 1'b1;
    ticks(50);
    check("t3_done_early", 64'(done_a), 64'd0);
    tick();
    check("t3_done", 64'(done_a), 64'd1);
    evt = 2'b11;
    ticks(5);
    evt = 2'b00;
    read_a("t3_cyc", 2'd0, 32'd64);
    read_a("t3_ch0", 2'd1, 32'd3);
    read_a("t3_ch1", 2'd2, 32'd1);
    check("t3_done_hold", 64'(done_a), 64'd1);
    start = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t3_clr_done", 64'(done_a), 64'd0);
    read_a("t3_clr_cyc", 2'd0, 32'd0);
    read_a("t3_clr_ch0", 2'd1, 32'd0);

    // 5: read on the same edge that increments ch0 from 4
    start = 1'b1;
    tick();
    evt = 2'b01;
    ticks(4);
    read_a("t5_same", 2'd1, 32'd4);
    start = 1'b0;
    evt = 2'b00;
    read_a("t5_later", 2'd1, 32'd5);
    read_a("t5_b2b_cyc", 2'd0, 32'd5);
    read_a("t5_b2b_ch0", 2'd1, 32'd5);
    read_a("t5_badsel", 2'd3, 32'd0);

    // 6: reset during a read request while running
    start = 1'b1;
    evt = 2'b11;
    ticks(3);
    rst = 1'b1;
    rd_req = 1'b1;
    rd_sel = 2'd0;
    tick();
    rst = 1'b0;
    rd_req = 1'b0;
    start = 1'b0;
    check("t6_ack", 64'(ack_a), 64'd0);
    check("t6_data", 64'(data_a), 64'd0);
    check("t6_done", 64'(done_a), 64'd0);
    ticks(3);
    read_a("t6_cyc_idle", 2'd0, 32'd0);
    read_a("t6_ch0_idle", 2'd1, 32'd0);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    evt = 2'b00;
    read_a("t6_cyc_resume", 2'd0, 32'd1);
    read_a("t6_ch1_resume", 2'd2, 32'd1);

    // 4: 8-bit counters, 257 ch0 events
    clr = 1'b1;
    tick();
    clr = 1'b0;
    start = 1'b1;
    tick();
    evt = 2'b01;
    ticks(257);
    start = 1'b0;
    evt = 2'b00;
    rd_req = 1'b1;
    rd_sel = 2'd1;
    tick();
    rd_req = 1'b0;
    check("t4_ack8", 64'(ack_b), 64'd1);
`ifdef PERF_SATURATE_EN
    check("t4_ch0_8", 64'(data_b), 64'd255);
`else
    check("t4_ch0_8", 64'(data_b), 64'd1);
`endif
    check("t4_ovf8", 64'(ovf_b), 64'b011);
    check("t4_done8", 64'(done_b), 64'd0);
    check("t4_ovf32", 64'(ovf_a), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
